// File: rtl/decode_stage_if.sv
// Handshake and decoded-record bus between fetch, the decode stage and the execute/control FSM.
interface decode_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned REG_W = 4
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  instr;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_class;
    logic [5:0]       out_opcode;
    logic [REG_W-1:0] out_rd;
    logic [REG_W-1:0] out_rs1;
    logic [REG_W-1:0] out_rs2;
    logic [XLEN-1:0]  out_imm;
    logic [1:0]       out_mode;
    logic [XLEN-1:0]  out_offset;
    logic             out_illegal;

    // Producer/consumer side: drives instructions and flush, takes decoded records.
    modport master (
        output flush, in_valid, instr, out_ready,
        input  in_ready, out_valid, out_class, out_opcode, out_rd, out_rs1, out_rs2,
               out_imm, out_mode, out_offset, out_illegal
    );

    // Decode stage side.
    modport slave (
        input  flush, in_valid, instr, out_ready,
        output in_ready, out_valid, out_class, out_opcode, out_rd, out_rs1, out_rs2,
               out_imm, out_mode, out_offset, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Buffered instruction-decode stage: splits fetched words into R/I/J/S fields,
// sign-extends immediate and jump offset, flags illegal opcodes and queues the
// decoded records in a DEPTH-entry FIFO. Head record is held in an output register.
// Optional macro DECODE_STATS_EN adds saturating per-class push counters.
module decode_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_W    = 4,
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned OFF_W    = 26,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned R_MAX_OP = 2,
    parameter int unsigned I_MAX_OP = 11,
    parameter int unsigned J_MAX_OP = 14,
    parameter int unsigned S_MAX_OP = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    decode_stage_if.slave       bus
`ifdef DECODE_STATS_EN
    ,
    output logic [15:0]         stat_r,
    output logic [15:0]         stat_i,
    output logic [15:0]         stat_j,
    output logic [15:0]         stat_s,
    output logic [15:0]         stat_ill
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    localparam logic [1:0] CLS_R = 2'd0;
    localparam logic [1:0] CLS_I = 2'd1;
    localparam logic [1:0] CLS_J = 2'd2;
    localparam logic [1:0] CLS_S = 2'd3;

    typedef struct packed {
        logic [1:0]       cls;
        logic [5:0]       opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
        logic [1:0]       mode;
        logic [XLEN-1:0]  offset;
        logic             illegal;
    } dec_rec_t;

    dec_rec_t         mem [DEPTH];
    dec_rec_t         head_q, head_d;
    dec_rec_t         dec;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             push, pop;

    logic [5:0]       opcode;
    logic [IMM_W-1:0] imm_raw;
    logic [OFF_W-1:0] off_raw;

    assign opcode  = bus.instr[31:26];
    assign imm_raw = bus.instr[IMM_W+1:2];
    assign off_raw = bus.instr[OFF_W-1:0];

    // Combinational decode of the incoming word; unused fields forced to zero.
    always_comb begin
        dec = '0;
        if (opcode <= 6'(R_MAX_OP)) begin
            dec.cls    = CLS_R;
            dec.opcode = opcode;
            dec.rd     = bus.instr[25 -: REG_W];
            dec.rs1    = bus.instr[21 -: REG_W];
            dec.rs2    = bus.instr[17 -: REG_W];
        end else if (opcode <= 6'(I_MAX_OP)) begin
            dec.cls    = CLS_I;
            dec.opcode = opcode;
            dec.rd     = bus.instr[25 -: REG_W];
            dec.rs1    = bus.instr[21 -: REG_W];
            dec.imm    = {{(XLEN-IMM_W){imm_raw[IMM_W-1]}}, imm_raw};
            dec.mode   = bus.instr[1:0];
        end else if (opcode <= 6'(J_MAX_OP)) begin
            dec.cls    = CLS_J;
            dec.opcode = opcode;
            dec.offset = {{(XLEN-OFF_W){off_raw[OFF_W-1]}}, off_raw};
        end else if (opcode <= 6'(S_MAX_OP)) begin
            dec.cls    = CLS_S;
            dec.opcode = opcode;
            dec.rd     = bus.instr[25 -: REG_W];
        end else begin
            dec.cls     = CLS_S;
            dec.illegal = 1'b1;
        end
    end

    assign push = bus.in_valid && in_ready_q && !bus.flush;
    assign pop  = out_valid_q && bus.out_ready && !bus.flush;

    // Next-state for pointers, occupancy, handshake flags and the head register.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
            if (pop)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
            case ({push, pop})
                2'b10:   count_d = CNT_W'(count_q + 1'b1);
                2'b01:   count_d = CNT_W'(count_q - 1'b1);
                default: count_d = count_q;
            endcase
        end
        // New head is the record being written when it lands in the head slot,
        // otherwise the stored entry; an empty FIFO keeps the last head visible.
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) head_d = dec;
            else                                head_d = mem[rd_ptr_d];
        end
        out_valid_d = (count_d != '0);
        in_ready_d  = (count_d != CNT_W'(DEPTH));
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Record storage, written at the push edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr_q] <= dec;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_class   = head_q.cls;
    assign bus.out_opcode  = head_q.opcode;
    assign bus.out_rd      = head_q.rd;
    assign bus.out_rs1     = head_q.rs1;
    assign bus.out_rs2     = head_q.rs2;
    assign bus.out_imm     = head_q.imm;
    assign bus.out_mode    = head_q.mode;
    assign bus.out_offset  = head_q.offset;
    assign bus.out_illegal = head_q.illegal;

`ifdef DECODE_STATS_EN
    // Saturating per-class push counters; cleared by reset only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_r   <= '0;
            stat_i   <= '0;
            stat_j   <= '0;
            stat_s   <= '0;
            stat_ill <= '0;
        end else if (push) begin
            if (dec.illegal) begin
                if (stat_ill != 16'hFFFF) stat_ill <= stat_ill + 16'd1;
            end else begin
                case (dec.cls)
                    CLS_R:   if (stat_r != 16'hFFFF) stat_r <= stat_r + 16'd1;
                    CLS_I:   if (stat_i != 16'hFFFF) stat_i <= stat_i + 16'd1;
                    CLS_J:   if (stat_j != 16'hFFFF) stat_j <= stat_j + 16'd1;
                    default: if (stat_s != 16'hFFFF) stat_s <= stat_s + 16'd1;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (DEPTH=2 default build).
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32), .REG_W(4)) bus ();

`ifdef DECODE_STATS_EN
    logic [15:0] stat_r, stat_i, stat_j, stat_s, stat_ill;
`endif

    decode_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef DECODE_STATS_EN
        ,
        .stat_r   (stat_r),
        .stat_i   (stat_i),
        .stat_j   (stat_j),
        .stat_s   (stat_s),
        .stat_ill (stat_ill)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every decoded field of the head record.
    task automatic chk_rec(input string tag, input logic [1:0] cls, input logic [5:0] op,
                           input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                           input logic [31:0] imm, input logic [1:0] mode,
                           input logic [31:0] off, input logic ill);
        chk({tag, ".class"},   32'(bus.out_class),   32'(cls));
        chk({tag, ".opcode"},  32'(bus.out_opcode),  32'(op));
        chk({tag, ".rd"},      32'(bus.out_rd),      32'(rd));
        chk({tag, ".rs1"},     32'(bus.out_rs1),     32'(rs1));
        chk({tag, ".rs2"},     32'(bus.out_rs2),     32'(rs2));
        chk({tag, ".imm"},     bus.out_imm,          imm);
        chk({tag, ".mode"},    32'(bus.out_mode),    32'(mode));
        chk({tag, ".offset"},  bus.out_offset,       off);
        chk({tag, ".illegal"}, 32'(bus.out_illegal), 32'(ill));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
        chk_rec("rst", 2'd0, 6'd0, 4'd0, 4'd0, 4'd0, 32'd0, 2'd0, 32'd0, 1'b0);

        // 1) R-type, one-cycle latency into empty FIFO
        rst_n         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.instr     = 32'h00D5C000;
        bus.out_ready = 1'b1;
        step();
        chk("t1.out_valid", 32'(bus.out_valid), 32'd1);
        chk_rec("t1", 2'd0, 6'd0, 4'd3, 4'd5, 4'd7, 32'd0, 2'd0, 32'd0, 1'b0);

        // 2) I-type, negative immediate (push and pop same cycle)
        bus.instr = 32'h0C4BFFF9;
        step();
        chk("t2.out_valid", 32'(bus.out_valid), 32'd1);
        chk_rec("t2", 2'd1, 6'd3, 4'd1, 4'd2, 4'd0, 32'hFFFFFFFE, 2'd1, 32'd0, 1'b0);

        // 3) J-type, all-ones offset
        bus.instr = 32'h33FFFFFF;
        step();
        chk_rec("t3", 2'd2, 6'd12, 4'd0, 4'd0, 4'd0, 32'd0, 2'd0, 32'hFFFFFFFF, 1'b0);

        // 4) illegal opcode 63
        bus.instr = 32'hFC000000;
        step();
        chk_rec("t4", 2'd3, 6'd0, 4'd0, 4'd0, 4'd0, 32'd0, 2'd0, 32'd0, 1'b1);
`ifdef DECODE_STATS_EN
        chk("t4.stat_ill", 32'(stat_ill), 32'd1);
        chk("t4.stat_r",   32'(stat_r),   32'd1);
        chk("t4.stat_i",   32'(stat_i),   32'd1);
        chk("t4.stat_j",   32'(stat_j),   32'd1);
        chk("t4.stat_s",   32'(stat_s),   32'd0);
`endif

        // Drain: empty FIFO keeps last head visible
        bus.in_valid = 1'b0;
        step();
        chk("drain.out_valid", 32'(bus.out_valid),   32'd0);
        chk("drain.in_ready",  32'(bus.in_ready),    32'd1);
        chk("drain.hold_ill",  32'(bus.out_illegal), 32'd1);
        chk("drain.hold_cls",  32'(bus.out_class),   32'd3);

        // 5) backpressure: A=S-type rd7, B=R op1 rd1, C=R op2
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = 32'h41C00000;
        step();
        chk("t5a.in_ready", 32'(bus.in_ready), 32'd1);
        chk_rec("t5a", 2'd3, 6'd16, 4'd7, 4'd0, 4'd0, 32'd0, 2'd0, 32'd0, 1'b0);
        bus.instr = 32'h04400000;
        step();
        chk("t5b.in_ready", 32'(bus.in_ready), 32'd0);
        chk("t5b.head_rd",  32'(bus.out_rd),   32'd7);
        bus.instr = 32'h08000000;
        step();
        chk("t5c.in_ready",  32'(bus.in_ready),  32'd0);
        chk("t5c.out_valid", 32'(bus.out_valid), 32'd1);
        chk_rec("t5c", 2'd3, 6'd16, 4'd7, 4'd0, 4'd0, 32'd0, 2'd0, 32'd0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        chk("t5d.in_ready", 32'(bus.in_ready), 32'd1);
        chk_rec("t5d", 2'd0, 6'd1, 4'd1, 4'd0, 4'd0, 32'd0, 2'd0, 32'd0, 1'b0);
        step();
        chk("t5e.out_valid", 32'(bus.out_valid), 32'd1);
        chk_rec("t5e", 2'd0, 6'd2, 4'd0, 4'd0, 4'd0, 32'd0, 2'd0, 32'd0, 1'b0);
        bus.in_valid = 1'b0;
        step();
        chk("t5f.out_valid", 32'(bus.out_valid), 32'd0);

        // 6a) fill with A,B then flush with a same-cycle push
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = 32'h41C00000;
        step();
        bus.instr = 32'h04400000;
        step();
        chk("t6.full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.flush = 1'b1;
        bus.instr = 32'h00D5C000;
        step();
        chk("t6.flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6.flush_in_ready",  32'(bus.in_ready),  32'd1);
        chk("t6.flush_hold_rd",   32'(bus.out_rd),    32'd7);
`ifdef DECODE_STATS_EN
        chk("t6.stat_r", 32'(stat_r), 32'd4);
        chk("t6.stat_s", 32'(stat_s), 32'd2);
`endif
        bus.flush = 1'b0;
        bus.instr = 32'h0C4BFFF9;
        step();
        chk("t6.post_out_valid", 32'(bus.out_valid), 32'd1);
        chk_rec("t6post", 2'd1, 6'd3, 4'd1, 4'd2, 4'd0, 32'hFFFFFFFE, 2'd1, 32'd0, 1'b0);

        // 6b) full FIFO, then reset with in_valid held
        bus.instr = 32'h33FFFFFF;
        step();
        chk("t6r.full_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        step();
        chk("t6r.out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6r.in_ready",  32'(bus.in_ready),  32'd1);
        chk_rec("t6r", 2'd0, 6'd0, 4'd0, 4'd0, 4'd0, 32'd0, 2'd0, 32'd0, 1'b0);
`ifdef DECODE_STATS_EN
        chk("t6r.stat_r",   32'(stat_r),   32'd0);
        chk("t6r.stat_ill", 32'(stat_ill), 32'd0);
`endif
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        step();
        chk("end.out_valid", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
